// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmit stage.
package uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // 16550 line status register bit positions
  localparam int unsigned LSR_OE   = 1;
  localparam int unsigned LSR_THRE = 5;
  localparam int unsigned LSR_TEMT = 6;

  localparam int unsigned DEFAULT_DIVISOR = 286;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separate occupancy counter; head entry is read combinationally.
module sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     lpc_clk,
  input  logic                     lpc_rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;

  always_ff @(posedge lpc_clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign level = level_q;
  assign full  = (level_q == LW'(DEPTH));
  assign empty = (level_q == '0);

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter fed by LPC data-port writes, with 16550-style line status.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH   = 16,
  parameter  int unsigned DIVISOR = DEFAULT_DIVISOR,
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic             lpc_clk,
  input  logic             lpc_rst,
  input  logic             wr_strobe,
  input  logic [7:0]       wr_data,
  input  logic             clr_overflow,
  output logic [LVL_W-1:0] fifo_level,
  output logic             fifo_full,
  output logic             fifo_empty,
  output logic             overflow,
  output logic             tx_idle,
  output logic [7:0]       lsr,
  output logic             uart_tx
);

  localparam int unsigned CW = $clog2(DIVISOR);

  tx_state_t     state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          tx_q;
  logic          overflow_q;
  logic [7:0]    head;
  logic          expiry;
  logic          pop;
  logic          push;
  logic          drop;

  assign expiry = (baud_cnt == CW'(DIVISOR - 1));
  // Popping on the final STOP cycle gives back-to-back frames with no idle gap.
  assign pop    = !fifo_empty && ((state == TX_IDLE) || ((state == TX_STOP) && expiry));
  assign push   = wr_strobe && (!fifo_full || pop);
  assign drop   = wr_strobe && fifo_full && !pop;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .lpc_clk(lpc_clk),
    .lpc_rst(lpc_rst),
    .push   (push),
    .pop    (pop),
    .din    (wr_data),
    .dout   (head),
    .level  (fifo_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end else if (clr_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  // The shifter is pre-shifted so the next data bit is always in shift[0].
  always_ff @(posedge lpc_clk) begin
    if (lpc_rst) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else if (pop) begin
      state    <= TX_START;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= head;
      tx_q     <= 1'b0;
    end else begin
      case (state)
        TX_START: begin
          if (expiry) begin
            state    <= TX_DATA;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= shift[0];
            shift    <= {1'b0, shift[7:1]};
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        TX_DATA: begin
          if (expiry) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= TX_STOP;
              tx_q  <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shift[0];
              shift   <= {1'b0, shift[7:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        TX_STOP: begin
          if (expiry) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
          tx_q <= 1'b1;
        end
        default: begin
          tx_q <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx  = tx_q;
  assign overflow = overflow_q;
  assign tx_idle  = fifo_empty && (state == TX_IDLE);

  always_comb begin
    lsr           = '0;
    lsr[LSR_OE]   = overflow_q;
    lsr[LSR_THRE] = fifo_empty;
    lsr[LSR_TEMT] = tx_idle;
  end

endmodule
